// File: rtl/npu_out_pkg.sv
// Shared select codes and state encoding for the NPU output sequencer.
// The DBG state exists only when NPU_OUT_SEQ_DBG_EN is defined.
package npu_out_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIFO,
    ST_TGT_L,
    ST_TGT_H,
`ifdef NPU_OUT_SEQ_DBG_EN
    ST_DBG,
`endif
    ST_DONE
  } state_t;

  localparam logic [2:0] SEL_FIFO  = 3'b000;
  localparam logic [2:0] SEL_TGT_L = 3'b001;
  localparam logic [2:0] SEL_TGT_H = 3'b010;
  localparam logic [2:0] SEL_DBG   = 3'b011;
  localparam logic [2:0] SEL_GND   = 3'b100;

  function automatic logic [2:0] sel_of(state_t s);
    case (s)
      ST_FIFO:  return SEL_FIFO;
      ST_TGT_L: return SEL_TGT_L;
      ST_TGT_H: return SEL_TGT_H;
`ifdef NPU_OUT_SEQ_DBG_EN
      ST_DBG:   return SEL_DBG;
`endif
      default:  return SEL_GND;
    endcase
  endfunction

endpackage

// File: rtl/npu_out_seq.sv
// Output frame sequencer: FIFO payload, target low/high bytes, optional debug
// bytes (NPU_OUT_SEQ_DBG_EN), driving a downstream byte mux via sel_out.
module npu_out_seq
  import npu_out_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int DBG_BYTES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] fifo_len,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [2:0]       sel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             piso_shift,
  output logic             busy,
  output logic             done
);

  if (DBG_BYTES < 1) begin : g_bad_dbg
    $error("DBG_BYTES must be at least 1");
  end

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             xfer;

`ifdef NPU_OUT_SEQ_DBG_EN
  localparam int DBG_W = (DBG_BYTES > 1) ? $clog2(DBG_BYTES) : 1;
  logic [DBG_W-1:0] dbg_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
`ifdef NPU_OUT_SEQ_DBG_EN
      dbg_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          cnt   <= fifo_len;
          state <= (fifo_len != '0) ? ST_FIFO : ST_TGT_L;
        end
        // Counter only ever decrements from a non-zero value, so it cannot wrap.
        ST_FIFO: if (xfer) begin
          cnt <= cnt - 1'b1;
          if (cnt == LEN_W'(1)) state <= ST_TGT_L;
        end
        ST_TGT_L: if (xfer) state <= ST_TGT_H;
        ST_TGT_H: if (xfer) begin
`ifdef NPU_OUT_SEQ_DBG_EN
          dbg_cnt <= '0;
          state   <= ST_DBG;
`else
          state   <= ST_DONE;
`endif
        end
`ifdef NPU_OUT_SEQ_DBG_EN
        ST_DBG: if (xfer) begin
          if (dbg_cnt == DBG_W'(DBG_BYTES - 1)) state <= ST_DONE;
          else dbg_cnt <= dbg_cnt + 1'b1;
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Valid is masked during reset so nothing is popped while the frame is abandoned.
  always_comb begin
    out_valid = 1'b0;
    case (state)
      ST_FIFO:  out_valid = !fifo_empty;
      ST_TGT_L: out_valid = 1'b1;
      ST_TGT_H: out_valid = 1'b1;
`ifdef NPU_OUT_SEQ_DBG_EN
      ST_DBG:   out_valid = 1'b1;
`endif
      default:  out_valid = 1'b0;
    endcase
    out_valid = out_valid && rst_n;
  end

  assign xfer       = out_valid && out_ready;
  assign sel_out    = sel_of(state);
  assign fifo_rd_en = xfer && (state == ST_FIFO);
`ifdef NPU_OUT_SEQ_DBG_EN
  assign piso_shift = xfer && (state == ST_DBG);
`else
  assign piso_shift = 1'b0;
`endif
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

endmodule

// File: doc/npu_out_seq.md
NPU_OUT_SEQ -- requirements
Module: npu_out_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of the FIFO byte-count input.
REQ-002 Parameter DBG_BYTES, default 2: debug bytes per frame (used only under NPU_OUT_SEQ_DBG_EN).
REQ-003 Clocking and reset SHALL be exactly: one clock; reset is synchronous and active-low. Ports are `clk` and `rst_n`.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 start  in  1  single-cycle frame request; ignored while busy=1.
REQ-007 fifo_len  in  LEN_W  number of FIFO bytes in the frame; sampled when start is accepted.
REQ-008 fifo_empty  in  1  FIFO has no word; FIFO is first-word-fall-through.
REQ-009 fifo_rd_en  out  1  FIFO pop strobe.
REQ-010 sel_out  out  3  select code for the downstream output mux.
REQ-011 out_valid  out  1  the current mux byte is valid.
REQ-012 out_ready  in  1  the consumer accepts the byte.
REQ-013 piso_shift  out  1  advance the debug PISO by one byte.
REQ-014 busy  out  1  a frame is in progress.
REQ-015 done  out  1  one-cycle pulse at frame end.

Function
REQ-016 The FSM states SHALL be IDLE, FIFO, TGT_L, TGT_H, DBG and DONE.
REQ-017 sel_out encoding SHALL be: IDLE/DONE=100, FIFO=000, TGT_L=001, TGT_H=010, DBG=011; it is decoded from the state register only, with no combinational input path.
REQ-018 A transfer SHALL be the condition out_valid && out_ready; the FSM advances only on a transfer, except in IDLE and DONE.
REQ-019 On IDLE with start=1, the block SHALL latch fifo_len into a remaining counter; next state is FIFO if fifo_len!=0, else TGT_L.
REQ-020 In FIFO, out_valid SHALL be !fifo_empty, and fifo_rd_en SHALL be transfer, combinational in the same cycle with no extra latency.
REQ-021 In FIFO, fifo_empty SHALL stall the frame: out_valid=0, no pop, state held indefinitely.
REQ-022 In FIFO, each transfer SHALL decrement the counter; the transfer at count 1 moves to TGT_L.
REQ-023 In TGT_L and TGT_H, out_valid SHALL be 1; a transfer moves TGT_L->TGT_H, and TGT_H->DBG (macro defined) or DONE (macro undefined).
REQ-024 In DBG, out_valid SHALL be 1, and piso_shift SHALL be transfer; after DBG_BYTES transfers the FSM moves to DONE.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE; start is ignored in DONE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 out_valid SHALL be 0 in IDLE and DONE; fifo_rd_en and piso_shift are never asserted outside FIFO and DBG respectively.
REQ-028 Once out_valid is asserted it SHALL hold its value and sel_out until a transfer occurs, except in FIFO, where it follows fifo_empty.
REQ-029 With fifo_len=2**LEN_W-1 (maximum), the block SHALL emit exactly that many FIFO bytes with no counter wrap.
REQ-030 Minimum frame latency SHALL be: start cycle, then the first valid byte in the next cycle.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force: state=IDLE, counter=0, sel_out=100, out_valid=0, fifo_rd_en=0, piso_shift=0, busy=0, done=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame, with no pop in the reset cycle and no done pulse.

Configuration
REQ-033 The macro NPU_OUT_SEQ_DBG_EN SHALL control the DBG state: when defined, DBG exists as specified; when undefined, DBG and its debug counter are not compiled, piso_shift is tied to 0, and select code 011 is never issued.

Structure
REQ-034 A shared package npu_out_pkg SHALL hold the sel_out code constants (SEL_FIFO, SEL_TGT_L, SEL_TGT_H, SEL_DBG, SEL_GND) and the state enum.
REQ-035 The block SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-036 Basic frame: fifo_len=3, FIFO never empty, out_ready=1 -> sel_out sequence 000,000,000,001,010 (then 011,011 with macro); 3 fifo_rd_en pulses; done one cycle after the last byte.
REQ-037 Zero length: fifo_len=0 -> no fifo_rd_en; first valid byte has sel_out=001.
REQ-038 Backpressure: out_ready=0 for 5 cycles during TGT_L -> sel_out=001 and out_valid=1 held stable; no state advance.
REQ-039 Underflow: fifo_empty=1 for 4 cycles in FIFO -> out_valid=0, fifo_rd_en=0; resumes with the correct remaining count.
REQ-040 Reset mid-frame: rst_n=0 in TGT_H -> next cycle IDLE, sel_out=100, busy=0, done never pulses.
REQ-041 start while busy: start pulsed in FIFO state -> ignored; the frame byte count is unchanged.
